// File: rtl/bcd_field_editor.sv
// Editable BCD field with wrap-around up/down stepping and key auto-repeat.
// Holding a key gives one step, then after REP_DELAY cycles a step every REP_RATE cycles.
module bcd_field_editor #(
  parameter int unsigned NDIG      = 2,
  parameter int unsigned REP_DELAY = 25000000,
  parameter int unsigned REP_RATE  = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*NDIG-1:0]   dato_in,
  input  logic [4*NDIG-1:0]   min_val,
  input  logic [4*NDIG-1:0]   max_val,
  input  logic                inc,
  input  logic                dec,
  output logic [4*NDIG-1:0]   dato_out,
  output logic                chg,
  output logic                rep
);

  localparam int unsigned W      = 4 * NDIG;
  localparam int unsigned CntMax = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CW-1:0] DelayEnd = CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] RateEnd  = CW'(REP_RATE - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   dato_q;
  logic           chg_q;
  logic           rep_q;
  logic           dir_up_q;

  logic           key_one;
  logic           load_ok;
  logic [W-1:0]   load_val;
  logic [W-1:0]   up_val;
  logic [W-1:0]   dn_val;
  logic [W-1:0]   step_val;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Valid BCD orders the same as plain binary, so bounds compare directly.
  always_comb begin
    key_one = inc ^ dec;
    load_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (dato_in[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
    load_val = load_ok ? dato_in : min_val;

    if (max_val < min_val || dato_q >= max_val) up_val = min_val;
    else                                         up_val = bcd_inc(dato_q);

    if (max_val < min_val)                            dn_val = min_val;
    else if (dato_q <= min_val || dato_q > max_val)   dn_val = max_val;
    else                                              dn_val = bcd_dec(dato_q);

    step_val = inc ? up_val : dn_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dato_q   <= min_val;
      chg_q    <= 1'b0;
      rep_q    <= 1'b0;
      dir_up_q <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (load) begin
        dato_q  <= load_val;
        chg_q   <= 1'b1;
        state_q <= StIdle;
        cnt_q   <= '0;
        rep_q   <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (key_one) begin
              dato_q   <= step_val;
              chg_q    <= 1'b1;
              dir_up_q <= inc;
              cnt_q    <= '0;
              state_q  <= StHold;
            end
          end
          StHold: begin
            if (!key_one || (inc != dir_up_q)) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == DelayEnd) begin
              dato_q  <= step_val;
              chg_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= StRepeat;
              rep_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRepeat: begin
            if (!key_one || (inc != dir_up_q)) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              rep_q   <= 1'b0;
            end else if (cnt_q == RateEnd) begin
              dato_q <= step_val;
              chg_q  <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dato_out = dato_q;
  assign chg      = chg_q;
  assign rep      = rep_q;

endmodule
